// File: rtl/clarvi_mem_arbiter.sv
// Shares one Avalon-MM style memory master between instruction fetch and load/store,
// routing returned read data back to the requester that issued each read.
module clarvi_mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_PENDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   instr_address,
    input  logic                    instr_read,
    output logic                    instr_wait,
    output logic [DATA_WIDTH-1:0]   instr_read_data,
    output logic                    instr_read_data_valid,
    input  logic [ADDR_WIDTH-1:0]   main_address,
    input  logic [DATA_WIDTH/8-1:0] main_byte_enable,
    input  logic                    main_read,
    input  logic                    main_write,
    input  logic [DATA_WIDTH-1:0]   main_write_data,
    output logic                    main_wait,
    output logic [DATA_WIDTH-1:0]   main_read_data,
    output logic                    main_read_data_valid,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    input  logic                    mem_wait,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    input  logic                    mem_read_data_valid,
    output logic                    protocol_error
);

    localparam int CW = $clog2(MAX_PENDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FIFO_FULL   = CW'(MAX_PENDING);
    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
    localparam logic          SRC_MAIN    = 1'b0;
    localparam logic          SRC_INSTR   = 1'b1;

    typedef enum logic [1:0] {IDLE, LOCK_INSTR, LOCK_MAIN} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   protocol_error_q, protocol_error_d;
    logic [MAX_PENDING-1:0] fifo_q, fifo_d;

    logic pop, push, push_src, read_ok, instr_req, main_req;
    logic grant_instr, grant_main;

    // Read data is shared; the per-requester valids do the routing.
    assign instr_read_data = mem_read_data;
    assign main_read_data  = mem_read_data;
    assign protocol_error  = protocol_error_q;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pop       = mem_read_data_valid && (count_q != '0);
        read_ok   = (count_q != FIFO_FULL) || pop;
        instr_req = instr_read && read_ok;
        main_req  = main_write || (main_read && read_ok);

        grant_instr = 1'b0;
        grant_main  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_req && (!main_req || starve_q == STARVE_MAX)) grant_instr = 1'b1;
                else if (main_req)                                     grant_main  = 1'b1;
            end
            LOCK_INSTR: grant_instr = instr_req;
            LOCK_MAIN:  grant_main  = main_req;
            default: ;
        endcase

        mem_address     = '0;
        mem_byte_enable = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_write_data  = '0;
        if (grant_instr) begin
            mem_address     = instr_address;
            mem_byte_enable = '1;
            mem_read        = 1'b1;
        end else if (grant_main) begin
            mem_address     = main_address;
            mem_byte_enable = main_byte_enable;
            mem_read        = main_read;
            mem_write       = main_write;
            mem_write_data  = main_write_data;
        end

        instr_wait = instr_read && !(grant_instr && !mem_wait);
        main_wait  = (main_read || main_write) && !(grant_main && !mem_wait);

        push     = !mem_wait && (grant_instr || (grant_main && main_read));
        push_src = grant_instr ? SRC_INSTR : SRC_MAIN;

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_instr && mem_wait)     state_d = LOCK_INSTR;
                else if (grant_main && mem_wait) state_d = LOCK_MAIN;
            end
            LOCK_INSTR: if (!grant_instr || !mem_wait) state_d = IDLE;
            LOCK_MAIN:  if (!grant_main  || !mem_wait) state_d = IDLE;
            default:    state_d = IDLE;
        endcase

        starve_d = starve_q;
        if (!instr_read || (grant_instr && !mem_wait))
            starve_d = '0;
        else if (state_q == IDLE && grant_main && starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;

        // Shift-register FIFO of source ids: head at bit 0.
        fifo_d = pop ? (fifo_q >> 1) : fifo_q;
        for (int i = 0; i < MAX_PENDING; i++) begin
            if (push && i == int'(count_q) - (pop ? 1 : 0)) fifo_d[i] = push_src;
        end

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        instr_read_data_valid = pop && (fifo_q[0] == SRC_INSTR);
        main_read_data_valid  = pop && (fifo_q[0] == SRC_MAIN);
        protocol_error_d      = protocol_error_q || (mem_read_data_valid && count_q == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            count_q          <= '0;
            starve_q         <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            starve_q         <= starve_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    // NOTE: FIFO storage needs no reset; count_q alone decides which entries are live.
    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_clarvi_mem_arbiter.sv
// Directed self-checking bench for clarvi_mem_arbiter with hand-computed expectations.
module tb_clarvi_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instr_address;
    logic        instr_read;
    logic        instr_wait;
    logic [31:0] instr_read_data;
    logic        instr_read_data_valid;
    logic [15:0] main_address;
    logic [3:0]  main_byte_enable;
    logic        main_read;
    logic        main_write;
    logic [31:0] main_write_data;
    logic        main_wait;
    logic [31:0] main_read_data;
    logic        main_read_data_valid;
    logic [15:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic        mem_wait;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;
    logic        protocol_error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    clarvi_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .instr_address(instr_address), .instr_read(instr_read), .instr_wait(instr_wait),
        .instr_read_data(instr_read_data), .instr_read_data_valid(instr_read_data_valid),
        .main_address(main_address), .main_byte_enable(main_byte_enable),
        .main_read(main_read), .main_write(main_write), .main_write_data(main_write_data),
        .main_wait(main_wait), .main_read_data(main_read_data),
        .main_read_data_valid(main_read_data_valid),
        .mem_address(mem_address), .mem_byte_enable(mem_byte_enable), .mem_read(mem_read),
        .mem_write(mem_write), .mem_write_data(mem_write_data), .mem_wait(mem_wait),
        .mem_read_data(mem_read_data), .mem_read_data_valid(mem_read_data_valid),
        .protocol_error(protocol_error)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        instr_address       = '0;
        instr_read          = 1'b0;
        main_address        = '0;
        main_byte_enable    = '0;
        main_read           = 1'b0;
        main_write          = 1'b0;
        main_write_data     = '0;
        mem_wait            = 1'b0;
        mem_read_data       = '0;
        mem_read_data_valid = 1'b0;
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Reset then idle
        sample();
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_instr_wait", instr_wait, 0);
        check("rst_main_wait", main_wait, 0);
        check("rst_valids", {main_read_data_valid, instr_read_data_valid}, 0);
        check("rst_perr", protocol_error, 0);

        // Simultaneous reads: main first, instr next cycle, data returned in order
        next_cycle();
        instr_read = 1'b1; instr_address = 16'h0100;
        main_read  = 1'b1; main_address  = 16'h0200; main_byte_enable = 4'hf;
        sample();
        check("both_addr", mem_address, 16'h0200);
        check("both_mem_read", mem_read, 1);
        check("both_main_wait", main_wait, 0);
        check("both_instr_wait", instr_wait, 1);
        next_cycle();
        main_read = 1'b0;
        sample();
        check("instr2_addr", mem_address, 16'h0100);
        check("instr2_wait", instr_wait, 0);
        check("instr2_be", mem_byte_enable, 4'hf);
        next_cycle();
        instr_read = 1'b0;
        mem_read_data_valid = 1'b1; mem_read_data = 32'hAAAA0000;
        sample();
        check("ret0_main_valid", main_read_data_valid, 1);
        check("ret0_main_data", main_read_data, 32'hAAAA0000);
        check("ret0_instr_valid", instr_read_data_valid, 0);
        next_cycle();
        mem_read_data = 32'h11112222;
        sample();
        check("ret1_instr_valid", instr_read_data_valid, 1);
        check("ret1_instr_data", instr_read_data, 32'h11112222);
        check("ret1_main_valid", main_read_data_valid, 0);

        // Write stalled by mem_wait locks the grant to main
        next_cycle();
        idle_inputs();
        main_write = 1'b1; main_address = 16'h0300; main_write_data = 32'hDEADBEEF;
        main_byte_enable = 4'b0011;
        instr_read = 1'b1; instr_address = 16'h0104;
        mem_wait = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            sample();
            check($sformatf("lock_c%0d_mem_write", c), mem_write, 1);
            check($sformatf("lock_c%0d_addr", c), mem_address, 16'h0300);
            check($sformatf("lock_c%0d_main_wait", c), main_wait, 1);
            check($sformatf("lock_c%0d_instr_wait", c), instr_wait, 1);
            next_cycle();
        end
        mem_wait = 1'b0;
        sample();
        check("lock_c4_main_wait", main_wait, 0);
        check("lock_c4_wdata", mem_write_data, 32'hDEADBEEF);
        check("lock_c4_be", mem_byte_enable, 4'b0011);
        check("lock_c4_instr_wait", instr_wait, 1);
        next_cycle();
        main_write = 1'b0;
        sample();
        check("lock_c5_instr_wait", instr_wait, 0);
        check("lock_c5_mem_read", mem_read, 1);
        check("lock_c5_addr", mem_address, 16'h0104);
        check("lock_c5_mem_write", mem_write, 0);
        next_cycle();
        instr_read = 1'b0;
        mem_read_data_valid = 1'b1; mem_read_data = 32'h00000055;
        sample();
        check("lock_ret_instr_valid", instr_read_data_valid, 1);
        check("lock_ret_data", instr_read_data, 32'h00000055);

        // Starvation: instr wins after exactly four losses to back-to-back writes
        next_cycle();
        idle_inputs();
        main_write = 1'b1; main_address = 16'h0400; main_byte_enable = 4'hf;
        instr_read = 1'b1; instr_address = 16'h0108;
        for (int c = 1; c <= 4; c++) begin
            sample();
            check($sformatf("starve_loss%0d_instr_wait", c), instr_wait, 1);
            check($sformatf("starve_loss%0d_main_wait", c), main_wait, 0);
            next_cycle();
        end
        sample();
        check("starve_win_instr_wait", instr_wait, 0);
        check("starve_win_main_wait", main_wait, 1);
        check("starve_win_addr", mem_address, 16'h0108);
        check("starve_win_mem_write", mem_write, 0);
        next_cycle();
        instr_read = 1'b0;
        mem_read_data_valid = 1'b1; mem_read_data = 32'h0000CAFE;
        sample();
        check("starve_after_main_wait", main_wait, 0);
        check("starve_ret_instr_valid", instr_read_data_valid, 1);

        // Full FIFO blocks reads, not writes; a pop frees a slot in the same cycle
        next_cycle();
        idle_inputs();
        main_read = 1'b1; main_address = 16'h0010; main_byte_enable = 4'hf;
        sample();
        check("full_rd0_wait", main_wait, 0);
        next_cycle();
        main_address = 16'h0011;
        sample();
        check("full_rd1_wait", main_wait, 0);
        next_cycle();
        main_address = 16'h0012;
        sample();
        check("full_blocked_wait", main_wait, 1);
        check("full_blocked_mem_read", mem_read, 0);
        next_cycle();
        main_read = 1'b0; main_write = 1'b1; main_address = 16'h0020;
        main_write_data = 32'h12345678;
        sample();
        check("full_write_wait", main_wait, 0);
        check("full_write_mem_write", mem_write, 1);
        next_cycle();
        main_write = 1'b0; main_read = 1'b1; main_address = 16'h0012;
        mem_read_data_valid = 1'b1; mem_read_data = 32'h00001111;
        sample();
        check("full_pop_issue_wait", main_wait, 0);
        check("full_pop_mem_read", mem_read, 1);
        check("full_pop_addr", mem_address, 16'h0012);
        check("full_pop_valid", main_read_data_valid, 1);
        next_cycle();
        main_read = 1'b0; mem_read_data = 32'h00002222;
        sample();
        check("full_drain1_valid", main_read_data_valid, 1);
        next_cycle();
        mem_read_data = 32'h00003333;
        sample();
        check("full_drain2_valid", main_read_data_valid, 1);
        check("full_drain2_data", main_read_data, 32'h00003333);
        check("full_drain2_perr", protocol_error, 0);

        // Spurious read data sets a sticky protocol error
        next_cycle();
        mem_read_data = 32'h00009999;
        sample();
        check("spur_valids", {main_read_data_valid, instr_read_data_valid}, 0);
        check("spur_perr_before", protocol_error, 0);
        next_cycle();
        idle_inputs();
        sample();
        check("spur_perr_set", protocol_error, 1);
        next_cycle();
        next_cycle();
        sample();
        check("spur_perr_sticky", protocol_error, 1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        sample();
        check("spur_perr_cleared", protocol_error, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
